// File: rtl/alu_pipe.sv
// RV32I OP/OP-IMM execute unit with a registered result and valid/ready on both sides.
// Define ALU_MDU_EN to build the iterative M-extension multiply/divide unit (ITER state).
module alu_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            alu_sel,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            illegal,
  output logic [1:0]      dbg_state_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // the producer holds its payload stable while valid is high and ready is low.
  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            illegal_q, illegal_d;
  logic            accept;
  logic            is_mdu;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    base_res;
  logic               base_ill;

  assign shamt     = y[SHAMT_W-1:0];
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_RESP) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_RESP);
  assign out       = out_q;
  assign illegal   = illegal_q;
  assign dbg_state_o = state_q;

  // In immediate form funct7 is part of the immediate except for the shift ops.
  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    case (funct3)
      3'b000: begin
        if (alu_sel || funct7 == 7'h00)  base_res = x + y;
        else if (funct7 == 7'h20)        base_res = x - y;
        else                             base_ill = 1'b1;
      end
      3'b001: begin
        if (funct7 == 7'h00) base_res = x << shamt;
        else                 base_ill = 1'b1;
      end
      3'b010: begin
        if (alu_sel || funct7 == 7'h00) base_res = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
        else                            base_ill = 1'b1;
      end
      3'b011: begin
        if (alu_sel || funct7 == 7'h00) base_res = {{(XLEN-1){1'b0}}, (x < y)};
        else                            base_ill = 1'b1;
      end
      3'b100: begin
        if (alu_sel || funct7 == 7'h00) base_res = x ^ y;
        else                            base_ill = 1'b1;
      end
      3'b101: begin
        if (funct7 == 7'h00)      base_res = x >> shamt;
        else if (funct7 == 7'h20) base_res = $unsigned($signed(x) >>> shamt);
        else                      base_ill = 1'b1;
      end
      3'b110: begin
        if (alu_sel || funct7 == 7'h00) base_res = x | y;
        else                            base_ill = 1'b1;
      end
      default: begin
        if (alu_sel || funct7 == 7'h00) base_res = x & y;
        else                            base_ill = 1'b1;
      end
    endcase
    if (base_ill) base_res = '0;
  end

`ifdef ALU_MDU_EN
  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [SHAMT_W:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic              signed_x, signed_y, x_neg, y_neg;
  logic [XLEN-1:0]   x_mag, y_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   quo, rem;

  assign is_mdu   = !alu_sel && (funct7 == 7'h01);
  assign mdu_done = (cnt_q == CNT_LAST);

  assign signed_y = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign signed_x = signed_y || (funct3 == 3'b010);
  assign x_neg    = signed_x && x[XLEN-1];
  assign y_neg    = signed_y && y[XLEN-1];
  assign x_mag    = x_neg ? -x : x;
  assign y_mag    = y_neg ? -y : y;

  // acc holds {high product, multiplier} for multiply and {remainder, quotient} for divide.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opb_q} & {(XLEN+1){acc_q[0]}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Divide by zero leaves quotient all ones and remainder |x|; qneg is held low for it
  // so the remainder sign fix-up alone restores x.
  assign prod = qneg_q ? -acc_q : acc_q;
  assign quo  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    case (op_q)
      3'b000:                 mdu_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: mdu_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         mdu_res = quo;
      default:                mdu_res = rem;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (accept && is_mdu) begin
      acc_d  = {{XLEN{1'b0}}, x_mag};
      opb_d  = y_mag;
      cnt_d  = '0;
      op_d   = funct3;
      qneg_d = (x_neg ^ y_neg) && (!funct3[2] || (y != '0));
      rneg_d = x_neg;
    end else if (state_q == S_ITER && !mdu_done) begin
      acc_d = op_q[2] ? div_next : mul_next;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign is_mdu   = 1'b0;
  assign mdu_done = 1'b0;
  assign mdu_res  = '0;
`endif

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    illegal_d = illegal_q;
    case (state_q)
      S_ITER: begin
        if (mdu_done) begin
          state_d   = S_RESP;
          out_d     = mdu_res;
          illegal_d = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          if (is_mdu) begin
            state_d = S_ITER;
          end else begin
            state_d   = S_RESP;
            out_d     = base_res;
            illegal_d = base_ill;
          end
        end else if (state_q == S_RESP && out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (XLEN=32): vector table through a result queue, plus hand-written
// latency, backpressure and reset sequences. MDU checks follow ALU_MDU_EN.
module tb_alu_pipe;

  localparam int W = 33;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        alu_sel;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        illegal;
  logic [1:0]  dbg_state;

  alu_pipe #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_sel     (alu_sel),
    .funct3      (funct3),
    .funct7      (funct7),
    .x           (x),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .illegal     (illegal),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] xv;
    logic [31:0] yv;
    logic [31:0] eo;
    logic        ei;
  } vec_t;

  vec_t        vecs[$];
  logic [W-1:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          bp_en    = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void add_vec(input logic sel, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] xv, input logic [31:0] yv,
                                  input logic [31:0] eo, input logic ei);
    vec_t v;
    v.sel = sel; v.f3 = f3; v.f7 = f7; v.xv = xv; v.yv = yv; v.eo = eo; v.ei = ei;
    vecs.push_back(v);
  endfunction

  // scoreboard: compares each accepted result against the oldest expected entry
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got out=%h illegal=%b, required no result", out, illegal);
        end else begin
          e = exp_q.pop_front();
          if ({illegal, out} !== e) begin
            n_fail++;
            $display("FAIL result: got illegal=%b out=%h, required illegal=%b out=%h",
                     illegal, out, e[32], e[31:0]);
          end
        end
      end
    end
  endtask

  // driver: called just after a rising edge, returns just after the accepting edge
  task automatic send(input logic sel, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] xa, input logic [31:0] ya,
                      input logic [31:0] eo, input logic ei);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    alu_sel  = sel;
    funct3   = f3;
    funct7   = f7;
    x        = xa;
    y        = ya;
    in_valid = 1'b1;
    exp_q.push_back({ei, eo});
    while (!done) begin
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
      #1;
      done = in_ready;
      @(posedge clk);
      #1;
      waits++;
      if (!done && waits > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", waits);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ir_low);
    lat    = 0;
    ir_low = 1'b1;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (in_ready !== 1'b0) ir_low = 1'b0;
    end
  endtask

  initial begin
    int  lat;
    bit  ir_low;
    int  drain;
    logic [31:0] ra, rb;
    int  pick;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_sel   = 1'b0;
    funct3    = 3'b000;
    funct7    = 7'h00;
    x         = '0;
    y         = '0;
    out_ready = 1'b1;

    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_out", {32'b0, out}, 64'd0);
    check("reset_illegal", {63'b0, illegal}, 64'd0);
    check("reset_state", {62'b0, dbg_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", {63'b0, in_ready}, 64'd1);

    // vector table
    add_vec(0, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,         0);
    add_vec(0, 3'b000, 7'h20, 32'd5,        32'd7,        32'hFFFFFFFE,   0);
    add_vec(1, 3'b000, 7'h7F, 32'd10,       32'hFFFFFFFF, 32'd9,          0);
    add_vec(0, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,          0);
    add_vec(0, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000,   0);
    add_vec(0, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000,   0);
    add_vec(1, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,          0);
    add_vec(1, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,          0);
    add_vec(0, 3'b001, 7'h00, 32'd1,        32'h23,       32'd8,          0);
    add_vec(1, 3'b001, 7'h20, 32'd1,        32'd3,        32'd0,          1);
    add_vec(1, 3'b101, 7'h20, 32'hF0000000, 32'd8,        32'hFFF00000,   0);
    add_vec(1, 3'b101, 7'h10, 32'hF0000000, 32'd8,        32'd0,          1);
    add_vec(0, 3'b100, 7'h00, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F,   0);
    add_vec(0, 3'b110, 7'h00, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F,   0);
    add_vec(0, 3'b111, 7'h00, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00,   0);
    add_vec(0, 3'b010, 7'h00, 32'h7FFFFFFF, 32'h80000000, 32'd0,          0);
    add_vec(0, 3'b011, 7'h00, 32'h7FFFFFFF, 32'h80000000, 32'd1,          0);
    add_vec(0, 3'b100, 7'h20, 32'h12345678, 32'h1,        32'd0,          1);
    add_vec(0, 3'b000, 7'h04, 32'd1,        32'd1,        32'd0,          1);
`ifdef ALU_MDU_EN
    add_vec(0, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD,   0);
    add_vec(0, 3'b011, 7'h01, 32'hFFFFFFFF, 32'd3,        32'h00000002,   0);
    add_vec(0, 3'b001, 7'h01, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF,   0);
    add_vec(0, 3'b010, 7'h01, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFF,   0);
    add_vec(0, 3'b100, 7'h01, 32'd7,        32'd0,        32'hFFFFFFFF,   0);
    add_vec(0, 3'b110, 7'h01, 32'd7,        32'd0,        32'd7,          0);
    add_vec(0, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   0);
    add_vec(0, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,          0);
    add_vec(0, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   0);
    add_vec(0, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   0);
    add_vec(0, 3'b101, 7'h01, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC,   0);
    add_vec(0, 3'b111, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd1,          0);
    add_vec(0, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9,   0);
`else
    add_vec(0, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3,        32'd0,          1);
    add_vec(0, 3'b100, 7'h01, 32'd7,        32'd2,        32'd0,          1);
`endif
    foreach (vecs[i])
      send(vecs[i].sel, vecs[i].f3, vecs[i].f7, vecs[i].xv, vecs[i].yv, vecs[i].eo, vecs[i].ei);

    // one-cycle latency of a base op
    @(posedge clk);
    #1;
    send(0, 3'b000, 7'h00, 32'd5, 32'd7, 32'd12, 0);
    check("base_latency_valid", {63'b0, out_valid}, 64'd1);
    check("base_latency_out", {32'b0, out}, 64'd12);

    // hold result under backpressure, then back-to-back accept
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 3'b000, 7'h00, 32'd1, 32'd2, 32'd3, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {63'b0, out_valid}, 64'd1);
      check("hold_out", {32'b0, out}, 64'd3);
      check("hold_in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(0, 3'b000, 7'h00, 32'd10, 32'd20, 32'd30, 0);
    check("b2b_valid", {63'b0, out_valid}, 64'd1);
    check("b2b_out", {32'b0, out}, 64'd30);

`ifdef ALU_MDU_EN
    // MDU latency and in_ready low while iterating
    @(posedge clk);
    #1;
    send(0, 3'b011, 7'h01, 32'hFFFFFFFF, 32'd3, 32'h2, 0);
    wait_out(lat, ir_low);
    check("mulhu_latency", lat, 64'd33);
    check("mulhu_in_ready_low", {63'b0, ir_low}, 64'd1);
    check("mulhu_out", {32'b0, out}, 64'h2);
    @(posedge clk);
    #1;
    send(0, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 0);
    wait_out(lat, ir_low);
    check("mul_latency", lat, 64'd33);
    check("mul_in_ready_low", {63'b0, ir_low}, 64'd1);
    @(posedge clk);
    #1;
    send(0, 3'b100, 7'h01, 32'd7, 32'd0, 32'hFFFFFFFF, 0);
    wait_out(lat, ir_low);
    check("divzero_latency", lat, 64'd33);

    // reset in the middle of an iteration
    @(posedge clk);
    #1;
    send(0, 3'b100, 7'h01, 32'd100, 32'd7, 32'd14, 0);
    repeat (10) @(posedge clk);
    #2;
`else
    // illegal MDU encoding completes in one cycle
    @(posedge clk);
    #1;
    send(0, 3'b000, 7'h01, 32'hFFFFFFFF, 32'd3, 32'd0, 1);
    check("mul_illegal_valid", {63'b0, out_valid}, 64'd1);
    check("mul_illegal_flag", {63'b0, illegal}, 64'd1);

    // reset while a result is held
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 3'b000, 7'h00, 32'd3, 32'd4, 32'd7, 0);
    repeat (2) @(posedge clk);
    #2;
`endif
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {63'b0, out_valid}, 64'd0);
    check("async_reset_out", {32'b0, out}, 64'd0);
    check("async_reset_state", {62'b0, dbg_state}, 64'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);
    check("post_reset_valid", {63'b0, out_valid}, 64'd0);

    // random base ops with random backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      pick = $urandom_range(0, 3);
      case (pick)
        0:       send(0, 3'b000, 7'h00, ra, rb, ra + rb, 0);
        1:       send(0, 3'b000, 7'h20, ra, rb, ra - rb, 0);
        2:       send(1, 3'b100, 7'(rb[11:5]), ra, rb, ra ^ rb, 0);
        default: send(0, 3'b001, 7'h00, ra, rb, ra << rb[4:0], 0);
      endcase
    end
    bp_en     = 1'b0;
    out_ready = 1'b1;
    drain     = 0;
    while (exp_q.size() != 0 && drain < 100) begin
      @(posedge clk);
      drain++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
